// File: rtl/boron_pkg.sv
// Shared Boron constants and controller state encoding, common to the encrypt and decrypt sequencers.
package boron_pkg;

    localparam int ROUNDS = 25;
    localparam int BLK_W  = 64;
    localparam int KEY_W  = 80;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYGEN = 3'd1,
        WHITEN = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/boron_decrypt_ctrl.sv
// Iterative Boron decryption sequencer: expands K0 to K25 (or reuses the cached K25),
// whitens, then walks the external inverse round and inverse key-schedule units down to K0.
module boron_decrypt_ctrl
    import boron_pkg::*;
#(
    parameter int ROUNDS = boron_pkg::ROUNDS,
    parameter int BLK_W  = boron_pkg::BLK_W,
    parameter int KEY_W  = boron_pkg::KEY_W,
    parameter int CNT_W  = boron_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [BLK_W-1:0] in_data_i,
    input  logic [KEY_W-1:0] in_key_i,
    input  logic             in_keep_key_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [BLK_W-1:0] out_data_o,
    output logic [BLK_W-1:0] rnd_data_o,
    output logic [KEY_W-1:0] rnd_key_o,
    output logic [CNT_W-1:0] rnd_cnt_o,
    input  logic [BLK_W-1:0] rnd_data_i,
    input  logic [KEY_W-1:0] key_fwd_i,
    input  logic [KEY_W-1:0] key_inv_i,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);

    state_t           r_state;
    logic [BLK_W-1:0] r_data;
    logic [KEY_W-1:0] r_key;
    logic [KEY_W-1:0] r_k25;
    logic             r_k25_vld;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_rdy;
    logic             r_out_vld;
    logic             r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_key     <= '0;
            r_k25     <= '0;
            r_k25_vld <= 1'b0;
            r_cnt     <= '0;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i && r_in_rdy) begin
                        r_data   <= in_data_i;
                        r_in_rdy <= 1'b0;
                        r_busy   <= 1'b1;
                        // A keep request without a cached K25 falls back to full expansion.
                        if (in_keep_key_i && r_k25_vld) begin
                            r_key   <= r_k25;
                            r_state <= WHITEN;
                        end else begin
                            r_key   <= in_key_i;
                            r_cnt   <= '0;
                            r_state <= KEYGEN;
                        end
                    end
                end
                KEYGEN: begin
                    r_key <= key_fwd_i;
                    if (r_cnt == CNT_LAST) begin
                        r_k25     <= key_fwd_i;
                        r_k25_vld <= 1'b1;
                        r_state   <= WHITEN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WHITEN: begin
                    r_data  <= r_data ^ r_key[BLK_W-1:0];
                    r_cnt   <= CNT_LAST;
                    r_state <= ROUND;
                end
                ROUND: begin
                    r_data <= rnd_data_i;
                    r_key  <= key_inv_i;
                    if (r_cnt == '0) begin
                        r_out_vld <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Ready rises only after the handshake edge, so a new block is taken a cycle later.
                    if (out_ready_i) begin
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_in_rdy  <= 1'b1;
                    r_out_vld <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_rdy;
    assign out_valid_o = r_out_vld;
    assign busy_o      = r_busy;
    assign out_data_o  = r_data;
    assign rnd_data_o  = r_data;
    assign rnd_key_o   = r_key;
    assign rnd_cnt_o   = r_cnt;

endmodule

// File: tb/tb_boron_decrypt_ctrl.sv
// Bench for boron_decrypt_ctrl with arithmetic stand-ins for the round and key-schedule units.
module tb_boron_decrypt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] in_data_i;
    logic [79:0] in_key_i;
    logic        in_keep_key_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_data_o;
    logic [63:0] rnd_data_o;
    logic [79:0] rnd_key_o;
    logic [4:0]  rnd_cnt_o;
    logic [63:0] rnd_data_i;
    logic [79:0] key_fwd_i;
    logic [79:0] key_inv_i;
    logic        busy_o;

    always #5 clk = ~clk;

    assign key_fwd_i  = rnd_key_o + 80'd1;
    assign key_inv_i  = rnd_key_o - 80'd1;
    assign rnd_data_i = rnd_data_o ^ key_inv_i[63:0];

    boron_decrypt_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .in_key_i      (in_key_i),
        .in_keep_key_i (in_keep_key_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .rnd_data_o    (rnd_data_o),
        .rnd_key_o     (rnd_key_o),
        .rnd_cnt_o     (rnd_cnt_o),
        .rnd_data_i    (rnd_data_i),
        .key_fwd_i     (key_fwd_i),
        .key_inv_i     (key_inv_i),
        .busy_o        (busy_o)
    );

    typedef struct {
        logic [63:0] data;
        logic [79:0] key;
        logic        keep;
        int          hold;
        logic [63:0] exp_data;
        logic [79:0] exp_k25;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[7];
    logic [63:0] sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Offers one block, tracks latency from the accepting edge, then drains the result.
    task automatic run_vec(input vec_t v, input string tag);
        int          n;
        int          w;
        bit          seen;
        bit          cnt_ok;
        bit          vld_ok;
        bit          dat_ok;
        bit          rdy_ok;
        logic [63:0] held;
        logic [63:0] exp;
        w = 0;
        while (!in_ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 128'(in_ready_o), 128'(1));
        out_ready_i   = (v.hold == 0);
        in_data_i     = v.data;
        in_key_i      = v.key;
        in_keep_key_i = v.keep;
        in_valid_i    = 1'b1;
        sb_q.push_back(v.exp_data);
        @(posedge clk);
        seen   = 1'b0;
        cnt_ok = 1'b1;
        for (n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) in_valid_i = 1'b0;
            if (n == v.exp_lat - 26) check({tag, "_k25"}, 128'(rnd_key_o), 128'(v.exp_k25));
            if (v.exp_lat == 27 && n >= 2 && n <= 26 && rnd_cnt_o != 5'(26 - n)) cnt_ok = 1'b0;
            if (out_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_latency"}, seen ? 128'(n) : 128'(0), 128'(v.exp_lat));
        if (v.exp_lat == 27) check({tag, "_cnt_seq"}, 128'(cnt_ok), 128'(1));
        if (v.hold > 0) begin
            held   = out_data_o;
            vld_ok = 1'b1;
            dat_ok = 1'b1;
            rdy_ok = 1'b1;
            in_valid_i = 1'b1;
            repeat (v.hold) begin
                @(negedge clk);
                if (out_valid_o !== 1'b1) vld_ok = 1'b0;
                if (out_data_o !== held)  dat_ok = 1'b0;
                if (in_ready_o !== 1'b0)  rdy_ok = 1'b0;
            end
            check({tag, "_bp_valid_stable"}, 128'(vld_ok), 128'(1));
            check({tag, "_bp_data_stable"}, 128'(dat_ok), 128'(1));
            check({tag, "_bp_no_ready"}, 128'(rdy_ok), 128'(1));
            out_ready_i = 1'b1;
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        check({tag, "_data"}, 128'(out_data_o), 128'(exp));
        @(negedge clk);
        in_valid_i = 1'b0;
        check({tag, "_post_valid"}, 128'(out_valid_o), 128'(0));
        check({tag, "_post_ready"}, 128'(in_ready_o), 128'(1));
        check({tag, "_post_busy"}, 128'(busy_o), 128'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{64'h0, 80'h0, 1'b1, 0, 64'h1, 80'd25, 52};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h1234, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 80'd25, 27};
        vecs[2] = '{64'h0, 80'h3, 1'b0, 0, 64'h1F, 80'd28, 52};
        vecs[3] = '{64'h1F, 80'h0, 1'b1, 0, 64'h0, 80'd28, 27};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 80'hFFFF_0000_0000_0000_0000, 1'b0, 0,
                    64'h0123_4567_89AB_CDEE, 80'hFFFF_0000_0000_0000_0019, 52};
        vecs[5] = '{64'h0, 80'h0000_FFFF_FFFF_FFFF_FFF0, 1'b0, 0,
                    64'h1, 80'h0001_0000_0000_0000_0009, 52};
        vecs[6] = '{64'hDEAD_BEEF_0000_0000, 80'h0, 1'b1, 10,
                    64'hDEAD_BEEF_0000_0001, 80'h0001_0000_0000_0000_0009, 27};

        rst           = 1'b1;
        in_valid_i    = 1'b0;
        in_data_i     = '0;
        in_key_i      = '0;
        in_keep_key_i = 1'b0;
        out_ready_i   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 128'(in_ready_o), 128'(1));
        check("reset_out_valid", 128'(out_valid_o), 128'(0));
        check("reset_busy", 128'(busy_o), 128'(0));
        check("reset_out_data", 128'(out_data_o), 128'(0));

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Cached-key block aborted by reset in the middle of the round phase.
        in_data_i     = 64'h5555_AAAA_5555_AAAA;
        in_key_i      = 80'h0;
        in_keep_key_i = 1'b1;
        in_valid_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_at_round10", 128'(rnd_cnt_o), 128'(10));
        rst = 1'b1;
        #1;
        check("abort_busy", 128'(busy_o), 128'(0));
        check("abort_in_ready", 128'(in_ready_o), 128'(1));
        check("abort_out_valid", 128'(out_valid_o), 128'(0));
        check("abort_out_data", 128'(out_data_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_vec('{64'h0, 80'h0, 1'b1, 0, 64'h1, 80'd25, 52}, "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/boron_decrypt_ctrl.md
Name: boron_decrypt_ctrl

Overview:
- Iterative sequencer for Boron block decryption: 64-bit block, 80-bit key.
- Owns the state, key, cached last-round-key and round-counter registers.
- Drives two external combinational units: the inverse round datapath (inverse round followed by round-key XOR, the add-round-key stage) and the forward/inverse 80-bit key-schedule step.
- Sits between the decryption top level's input/output handshakes and those combinational units.

Parameters:
- ROUNDS, 25, number of Boron rounds.
- BLK_W, 64, block width.
- KEY_W, 80, key width.
- CNT_W, 5, round counter width; must satisfy 2**CNT_W > ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  ciphertext/key offered.
- in_ready_o  out  1  controller can accept.
- in_data_i  in  BLK_W  ciphertext.
- in_key_i  in  KEY_W  master key K0.
- in_keep_key_i  in  1  reuse the cached K25 and skip key expansion.
- out_valid_o  out  1  plaintext valid.
- out_ready_i  in  1  sink accepts plaintext.
- out_data_o  out  BLK_W  plaintext (data register).
- rnd_data_o  out  BLK_W  data register to the round unit.
- rnd_key_o  out  KEY_W  key register to the key-schedule units.
- rnd_cnt_o  out  CNT_W  current round index.
- rnd_data_i  in  BLK_W  round-unit result: inverse round of rnd_data_o, XORed with key_inv_i[63:0].
- key_fwd_i  in  KEY_W  forward schedule step of (rnd_key_o, rnd_cnt_o).
- key_inv_i  in  KEY_W  inverse schedule step of (rnd_key_o, rnd_cnt_o).
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, data_reg=0, key_reg=0, k25_reg=0, k25_vld=0, cnt=0. Outputs: in_ready_o=1, out_valid_o=0, busy_o=0, out_data_o=0.
- States: IDLE, KEYGEN, WHITEN, ROUND, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o, data_reg<=in_data_i.
  - If in_keep_key_i & k25_vld: key_reg<=k25_reg, next state WHITEN.
  - Otherwise: key_reg<=in_key_i, cnt<=0, next state KEYGEN.
  - in_keep_key_i while k25_vld=0 is treated as 0.
- KEYGEN:
  - Each cycle key_reg<=key_fwd_i, cnt<=cnt+1.
  - At cnt==ROUNDS-1: k25_reg<=key_fwd_i, k25_vld<=1, next state WHITEN.
  - Lasts exactly ROUNDS cycles.
- WHITEN (1 cycle): data_reg<=data_reg ^ key_reg[63:0], cnt<=ROUNDS-1, next state ROUND.
- ROUND:
  - Each cycle data_reg<=rnd_data_i and key_reg<=key_inv_i, so the key register steps K(c+1) to Kc.
  - cnt decrements; at cnt==0 next state DONE.
  - Lasts exactly ROUNDS cycles.
- DONE:
  - out_valid_o=1; out_data_o holds data_reg stable until out_valid_o & out_ready_i.
  - After the handshake: next state IDLE.
  - If out_ready_i is already high on entry, DONE lasts 1 cycle.
- Latency, from the accepting edge to the first cycle with out_valid_o high: ROUNDS*2+2 = 52 cycles with key expansion, ROUNDS+2 = 27 with the cached key.
- in_ready_o=0 outside IDLE. No new block is accepted in the cycle of the output handshake; the earliest next accept is in the following cycle.
- rnd_cnt_o=cnt and rnd_key_o=key_reg at all times.
- Counter never wraps: it counts down only in ROUND and up only in KEYGEN, within 0..ROUNDS-1.
- Reset mid-operation aborts immediately:
  - k25_vld clears, so the next block always expands its key.
  - No partial output is ever flagged valid.

Decomposition:
- Package boron_pkg:
  - BLK_W, KEY_W, ROUNDS, CNT_W constants.
  - State enum typedef (IDLE, KEYGEN, WHITEN, ROUND, DONE).
  - Shared with the encryption controller.
- No sub-module needed: a single FSM plus registers.
- The round and key-schedule units stay external, instantiated by the decryption top level.

Test Plan:
- Bench stubs for all tests: key_fwd_i=key+1, key_inv_i=key-1, rnd_data_i=rnd_data_o ^ key_inv_i[63:0].
- Reset state: after rst, check in_ready_o=1, out_valid_o=0, busy_o=0, out_data_o=0.
- Full decryption: key=0, data=0, keep=0, out_ready_i=1 → out_valid_o exactly 52 cycles after accept, out_data_o=0x0000_0000_0000_0001, k25_reg=25.
- Cached key: immediately follow with data=0xFFFF_FFFF_FFFF_FFFF, keep=1 → out_valid_o after 27 cycles, out_data_o=0xFFFF_FFFF_FFFF_FFFE; rnd_cnt_o sequence 24..0 in ROUND.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE → out_valid_o and out_data_o stable, in_ready_o=0; release → IDLE next cycle.
- Reset mid-ROUND: assert rst at round 10 → same cycle busy_o=0, in_ready_o=1. Next block sent with keep=1 → still takes the 52-cycle path.
- keep=1 with no valid cache (first block after reset) → KEYGEN is taken and the result matches the non-cached scenario.
